rdm_harq_combiner: RTL

- Sits directly downstream of the rate-dematching read FSM and consumes its 96-bit words of 16 six-bit LLRs.
- Requests the data stream, then saturating-adds each word into an external HARQ combine RAM at a circular address modulo the Ncb word count.
- Repetitions (E > Ncb) therefore soft-combine onto the same circular buffer.
- Reports completion to the top-level combine sequencer.

---
 rtl/rdm_harq_combiner.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rdm_harq_combiner.sv
// -----------------------------------------------------------------------------
// rdm_harq_combiner
//
// Accepts 96-bit words of 16 signed 6-bit LLRs from the rate-dematching read
// FSM and soft-combines each word into an external HARQ combine RAM. Words
// land at a circular address modulo Ncb, so repetitions (E > Ncb) accumulate
// onto the same buffer. Each lane is a saturating add clamped to [-31,+31].
//
// Ports:
//   i_core_clk, i_rx_rstn     clock, asynchronous active-low reset
//   i_combine_start           start pulse (sampled only when idle)
//   i_ncb_words, i_e_words    circular length / words to receive (latched)
//   i_first_tx                1 = first pass overwrites instead of adding
//   o_rdm_data_request        one-cycle request pulse to the dematcher
//   i_rdm_data_valid/_data    upstream LLR word stream (no backpressure)
//   o_ram_rd_en/_addr         combine RAM read port (1-cycle latency)
//   i_ram_rd_data             combine RAM read data (old data on collision)
//   o_ram_wr_en/_addr/_data   combine RAM write port
//   o_busy                    high whenever not idle
//   o_done                    one-cycle completion pulse
// -----------------------------------------------------------------------------
module rdm_harq_combiner #(
    parameter int LLR_W   = 6,
    parameter int NUM_LLR = 16,
    parameter int ADDR_W  = 12
) (
    input  logic                     i_core_clk,
    input  logic                     i_rx_rstn,
    input  logic                     i_combine_start,
    input  logic [ADDR_W-1:0]        i_ncb_words,
    input  logic [ADDR_W-1:0]        i_e_words,
    input  logic                     i_first_tx,
    output logic                     o_rdm_data_request,
    input  logic                     i_rdm_data_valid,
    input  logic [LLR_W*NUM_LLR-1:0] i_rdm_data,
    output logic                     o_ram_rd_en,
    output logic [ADDR_W-1:0]        o_ram_rd_addr,
    input  logic [LLR_W*NUM_LLR-1:0] i_ram_rd_data,
    output logic                     o_ram_wr_en,
    output logic [ADDR_W-1:0]        o_ram_wr_addr,
    output logic [LLR_W*NUM_LLR-1:0] o_ram_wr_data,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int unsigned DATA_W = LLR_W * NUM_LLR;

    localparam logic [LLR_W-1:0]        LLR_MIN    = {1'b1, {(LLR_W-1){1'b0}}};
    localparam logic [LLR_W-1:0]        LLR_MIN_P1 = {1'b1, {(LLR_W-2){1'b0}}, 1'b1};
    localparam logic signed [LLR_W:0]   POS_LIM    = {2'b00, {(LLR_W-1){1'b1}}};
    localparam logic signed [LLR_W:0]   NEG_LIM    = {2'b11, {(LLR_W-2){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    // Latched configuration and counters
    logic [ADDR_W-1:0] ncb_words;
    logic [ADDR_W-1:0] e_words;
    logic              first_tx;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] word_cnt;
    logic [3:0]        pass_cnt;
    logic              drain_cnt;

    logic              accept;
    logic [ADDR_W-1:0] wr_addr_inc;
    logic [ADDR_W-1:0] word_cnt_inc;
    logic [DATA_W-1:0] in_clean;

    // Stage 1: word accepted last cycle, RAM data arriving now
    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic              s1_zero;
    logic [DATA_W-1:0] s1_new;

    // Stage 2: registered sum being written
    logic              s2_valid;
    logic [ADDR_W-1:0] s2_addr;
    logic [DATA_W-1:0] s2_data;

    // Most recently written word (covers the RAM read-during-write window)
    logic              h_valid;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;

    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] sum_word;

    function automatic logic [LLR_W-1:0] sat_add(input logic [LLR_W-1:0] a,
                                                 input logic [LLR_W-1:0] b);
        logic signed [LLR_W:0] s;
        s = $signed({a[LLR_W-1], a}) + $signed({b[LLR_W-1], b});
        if (s > POS_LIM)
            s = POS_LIM;
        else if (s < NEG_LIM)
            s = NEG_LIM;
        return s[LLR_W-1:0];
    endfunction

    assign accept       = (state == RUN) && i_rdm_data_valid;
    assign wr_addr_inc  = wr_addr + 1'b1;
    assign word_cnt_inc = word_cnt + 1'b1;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (i_combine_start) state_nxt = REQ;
            REQ:     state_nxt = RUN;
            RUN:     if (accept && (word_cnt_inc == e_words)) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        o_rdm_data_request = (state == REQ);
        o_busy             = (state != IDLE);
        o_done             = (state == DONE);
    end

    // -------------------------------------------------------------------------
    // Config latch, circular address, counters
    // -------------------------------------------------------------------------
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            ncb_words <= '0;
            e_words   <= '0;
            first_tx  <= 1'b0;
            wr_addr   <= '0;
            word_cnt  <= '0;
            pass_cnt  <= '0;
            drain_cnt <= 1'b0;
        end else begin
            drain_cnt <= (state == DRAIN);
            if ((state == IDLE) && i_combine_start) begin
                ncb_words <= i_ncb_words;
                e_words   <= i_e_words;
                first_tx  <= i_first_tx;
                wr_addr   <= '0;
                word_cnt  <= '0;
                pass_cnt  <= '0;
            end else if (accept) begin
                word_cnt <= word_cnt_inc;
                if (wr_addr_inc == ncb_words) begin
                    wr_addr <= '0;
                    if (pass_cnt != 4'hF)
                        pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    wr_addr <= wr_addr_inc;
                end
            end
        end
    end

    // -32 has no positive counterpart; fold it to -31 before combining
    always_comb begin
        in_clean = i_rdm_data;
        for (int unsigned k = 0; k < NUM_LLR; k++) begin
            if (i_rdm_data[k*LLR_W +: LLR_W] == LLR_MIN)
                in_clean[k*LLR_W +: LLR_W] = LLR_MIN_P1;
        end
    end

    // Old value: zero override on first pass, else youngest in-flight write
    // to the same address, else RAM data.
    always_comb begin
        old_word = i_ram_rd_data;
        if (s2_valid && (s2_addr == s1_addr))
            old_word = s2_data;
        else if (h_valid && (h_addr == s1_addr))
            old_word = h_data;
        if (s1_zero)
            old_word = '0;
    end

    always_comb begin
        sum_word = '0;
        for (int unsigned k = 0; k < NUM_LLR; k++)
            sum_word[k*LLR_W +: LLR_W] = sat_add(old_word[k*LLR_W +: LLR_W],
                                                 s1_new[k*LLR_W +: LLR_W]);
    end

    // -------------------------------------------------------------------------
    // Pipeline registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_zero  <= 1'b0;
            s1_new   <= '0;
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_data  <= '0;
            h_valid  <= 1'b0;
            h_addr   <= '0;
            h_data   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_addr <= wr_addr;
                s1_zero <= first_tx && (pass_cnt == 4'd0);
                s1_new  <= in_clean;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_addr <= s1_addr;
                s2_data <= sum_word;
            end
            // History restarts per job so externally reloaded RAM is honoured
            if ((state == IDLE) && i_combine_start) begin
                h_valid <= 1'b0;
            end else if (s2_valid) begin
                h_valid <= 1'b1;
                h_addr  <= s2_addr;
                h_data  <= s2_data;
            end
        end
    end

    assign o_ram_rd_en   = accept;
    assign o_ram_rd_addr = wr_addr;
    assign o_ram_wr_en   = s2_valid;
    assign o_ram_wr_addr = s2_addr;
    assign o_ram_wr_data = s2_data;

endmodule
